// File: rtl/vreg_pipe_pkg.sv
// rtl/vreg_pipe_pkg.sv - shared constants and helpers for the elastic register pipeline
package vreg_pipe_pkg;

    localparam int TRACE_W = 16;

    localparam logic [7:0] GLYPH_EMPTY = ".";
    localparam logic [7:0] GLYPH_FULL  = "#";
    localparam logic [7:0] GLYPH_BAR   = "|";

    // Bits needed to hold the values 0..n inclusive.
    function automatic int clog2p1(input int n);
        int r;
        r = 0;
        while ((1 << r) < (n + 1)) r++;
        return r;
    endfunction

endpackage

// File: rtl/vreg_pipe_stage.sv
// rtl/vreg_pipe_stage.sv - one elastic stage: valid flop, data flop and load enable
module vreg_pipe_stage #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               adv,
    input  logic               src_val,
    input  logic [p_nbits-1:0] src_msg,
    output logic               val,
    output logic [p_nbits-1:0] msg
);

    logic load;

    // The stage takes a new entry whenever its current one is leaving or it is empty.
    assign load = !val || adv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val <= 1'b0;
            msg <= '0;
        end else if (flush) begin
            val <= 1'b0;
        end else if (load) begin
            val <= src_val;
            if (src_val) msg <= src_msg;
        end
    end

endmodule

// File: rtl/vreg_pipe.sv
// rtl/vreg_pipe.sv - stallable val/rdy register pipeline; optional line trace under VREG_PIPE_TRACE_EN
module vreg_pipe
    import vreg_pipe_pkg::*;
#(
    parameter int p_nbits   = 32,
    parameter int p_nstages = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_val,
    output logic                             in_rdy,
    input  logic [p_nbits-1:0]               in_msg,
    output logic                             out_val,
    input  logic                             out_rdy,
    output logic [p_nbits-1:0]               out_msg,
    output logic [clog2p1(p_nstages)-1:0]    count
);

    localparam int LAST = p_nstages - 1;
    localparam int CW   = clog2p1(p_nstages);

    logic [p_nstages-1:0] v;
    logic [p_nstages-1:0] adv;
    logic [p_nbits-1:0]   d [p_nstages];
    logic                 in_xfer;

    // Ready ripples from the output back toward the input; empty stages pass it through.
    always_comb begin
        logic nxt;
        adv = '0;
        nxt = out_rdy;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = nxt;
            nxt    = !v[k] || nxt;
        end
    end

    assign in_rdy  = !flush && (!v[0] || adv[0]);
    assign in_xfer = in_val && in_rdy;
    assign out_val = v[LAST] && !flush;
    assign out_msg = d[LAST];

    for (genvar k = 0; k < p_nstages; k++) begin : g_stage
        logic               s_val;
        logic [p_nbits-1:0] s_msg;

        if (k == 0) begin : g_head
            assign s_val = in_xfer;
            assign s_msg = in_msg;
        end else begin : g_body
            assign s_val = v[k-1];
            assign s_msg = d[k-1];
        end

        vreg_pipe_stage #(.p_nbits(p_nbits)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .adv     (adv[k]),
            .src_val (s_val),
            .src_msg (s_msg),
            .val     (v[k]),
            .msg     (d[k])
        );
    end

    always_comb begin
        count = '0;
        for (int k = 0; k < p_nstages; k++) count = count + CW'(v[k]);
    end

`ifdef VREG_PIPE_TRACE_EN
    string trace_str;

    always @(posedge clk) begin
        string s;
        string q_str;
        string pad;
        $sformat(s, "%c", GLYPH_BAR);
        for (int k = 0; k < p_nstages; k++)
            $sformat(s, "%s%c", s, v[k] ? GLYPH_FULL : GLYPH_EMPTY);
        $sformat(s, "%s%c", s, GLYPH_BAR);
        $sformat(q_str, " q = %d", out_msg);
        if (!out_val) begin
            pad = "";
            for (int i = 0; i < q_str.len(); i++)
                $sformat(pad, "%s ", pad);
            q_str = pad;
        end
        $sformat(trace_str, "%s%s", s, q_str);
    end
`endif

endmodule

// File: tb/tb_vreg_pipe.sv
// tb/tb_vreg_pipe.sv - directed self-checking bench for vreg_pipe (3-stage and 1-stage builds)
module tb_vreg_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [31:0] in_msg = '0;
    logic        out_val;
    logic        out_rdy = 1'b0;
    logic [31:0] out_msg;
    logic [1:0]  count;

    logic        flush1 = 1'b0;
    logic        in1_val = 1'b0;
    logic        in1_rdy;
    logic [31:0] in1_msg = '0;
    logic        out1_val;
    logic        out1_rdy = 1'b0;
    logic [31:0] out1_msg;
    logic [0:0]  count1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    vreg_pipe #(.p_nbits(32), .p_nstages(3)) u3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
        .count(count)
    );

    vreg_pipe #(.p_nbits(32), .p_nstages(1)) u1 (
        .clk(clk), .reset(reset), .flush(flush1),
        .in_val(in1_val), .in_rdy(in1_rdy), .in_msg(in1_msg),
        .out_val(out1_val), .out_rdy(out1_rdy), .out_msg(out1_msg),
        .count(count1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] q[$];
        bit          r1 [8];
        int          next_msg;
        int          accepted;
        int          popped;

        // reset state
        #3;
        chk("rst_out_val", out_val, 0);
        chk("rst_out_msg", out_msg, 0);
        chk("rst_count", count, 0);
        chk("rst_in_rdy", in_rdy, 1);
        cyc();
        reset = 1'b1;
        cyc();

        // single message latency
        in_val = 1; in_msg = 32'hDEADBEEF; out_rdy = 1;
        #1 chk("t1_in_rdy", in_rdy, 1);
        cyc(); in_val = 0;
        #1 chk("t1_c6_count", count, 1); chk("t1_c6_val", out_val, 0);
        cyc();
        #1 chk("t1_c7_count", count, 1); chk("t1_c7_val", out_val, 0);
        cyc();
        #1 chk("t1_c8_count", count, 1); chk("t1_c8_val", out_val, 1);
        chk("t1_c8_msg", out_msg, 32'hDEADBEEF);
        cyc();
        #1 chk("t1_c9_val", out_val, 0); chk("t1_c9_count", count, 0);

        // back-to-back stream 1..10
        for (int c = 0; c < 13; c++) begin
            if (c < 10) begin in_val = 1; in_msg = 32'(c + 1); end
            else in_val = 0;
            #1;
            if (c < 10) chk("t2_in_rdy", in_rdy, 1);
            if (c >= 3) begin
                chk("t2_out_val", out_val, 1);
                chk("t2_out_msg", out_msg, 64'(c - 2));
            end else begin
                chk("t2_out_idle", out_val, 0);
            end
            cyc();
        end
        #1 chk("t2_drained", count, 0);

        // stall then release
        out_rdy = 0;
        for (int i = 1; i <= 3; i++) begin
            in_val = 1; in_msg = 32'(i);
            #1 chk("t3_fill_rdy", in_rdy, 1);
            cyc();
        end
        in_msg = 4;
        #1 chk("t3_full_rdy", in_rdy, 0); chk("t3_full_count", count, 3);
        chk("t3_full_val", out_val, 1); chk("t3_full_msg", out_msg, 1);
        cyc();
        #1 chk("t3_hold_rdy", in_rdy, 0); chk("t3_hold_count", count, 3);
        out_rdy = 1;
        #1 chk("t3_release_rdy", in_rdy, 1); chk("t3_release_msg", out_msg, 1);
        cyc(); in_val = 0;
        for (int k = 2; k <= 4; k++) begin
            #1 chk("t3_out_val", out_val, 1); chk("t3_out_msg", out_msg, 64'(k));
            cyc();
        end
        #1 chk("t3_drained", count, 0);

        // flush on a full pipe
        out_rdy = 0;
        for (int i = 11; i <= 13; i++) begin
            in_val = 1; in_msg = 32'(i);
            cyc();
        end
        in_msg = 14;
        #1 chk("t4_full", count, 3);
        out_rdy = 1; flush = 1;
        #1 chk("t4_flush_in_rdy", in_rdy, 0); chk("t4_flush_out_val", out_val, 0);
        cyc(); flush = 0;
        #1 chk("t4_post_count", count, 0); chk("t4_post_val", out_val, 0);
        chk("t4_post_rdy", in_rdy, 1);
        cyc(); in_val = 0;
        cyc();
        cyc();
        #1 chk("t4_out_val", out_val, 1); chk("t4_out_msg", out_msg, 14);
        cyc();

        // asynchronous reset mid-stream
        out_rdy = 0;
        in_val = 1; in_msg = 21;
        cyc(); in_msg = 22;
        cyc(); in_val = 0;
        #1 chk("t5_pre_count", count, 2);
        #1 reset = 0;
        #1 chk("t5_rst_val", out_val, 0); chk("t5_rst_count", count, 0);
        chk("t5_rst_msg", out_msg, 0);
        cyc();
        reset = 1; out_rdy = 1; in_val = 1; in_msg = 5;
        #1 chk("t5_rdy", in_rdy, 1); chk("t5_count", count, 0);
        cyc(); in_val = 0;
        cyc();
        cyc();
        #1 chk("t5_out_val", out_val, 1); chk("t5_out_msg", out_msg, 5);
        cyc();
        #1 chk("t5_drained", out_val, 0);

        // single-stage build with scoreboard
        r1 = '{1, 0, 1, 1, 0, 0, 1, 1};
        next_msg = 100;
        accepted = 0;
        popped = 0;
        for (int i = 0; i < 8; i++) begin
            in1_val = 1; in1_msg = 32'(next_msg); out1_rdy = r1[i];
            #1;
            chk("t6_in_rdy", in1_rdy, (q.size() == 0) || out1_rdy);
            chk("t6_out_val", out1_val, q.size() != 0);
            chk("t6_count", count1, 64'(q.size()));
            if (q.size() != 0) chk("t6_out_msg", out1_msg, q[0]);
            if (out1_val && out1_rdy && q.size() != 0) begin
                void'(q.pop_front());
                popped++;
            end
            if (in1_val && in1_rdy) begin
                q.push_back(32'(next_msg));
                next_msg++;
                accepted++;
            end
            cyc();
        end
        in1_val = 0; out1_rdy = 1;
        #1 chk("t6_tail_val", out1_val, q.size() != 0);
        if (q.size() != 0) begin
            chk("t6_tail_msg", out1_msg, q[0]);
            void'(q.pop_front());
            popped++;
        end
        cyc();
        #1 chk("t6_empty", count1, 0);
        chk("t6_balance", 64'(popped), 64'(accepted));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
